// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Scan request / snapshot handshake bundle between the sequencer and its user.
interface mux_scan_sequencer_if;

    logic                          start;
    logic [mux_scan_pkg::N_CH-1:0] mask;
    logic                          busy;
    logic [mux_scan_pkg::N_CH-1:0] word;
    logic                          word_valid;
    logic                          word_ready;

    // sequencer side: produces the snapshot word
    modport master (
        input  start,
        input  mask,
        input  word_ready,
        output busy,
        output word,
        output word_valid
    );

    // user side: requests scans and consumes snapshots
    modport slave (
        output start,
        output mask,
        output word_ready,
        input  busy,
        input  word,
        input  word_valid
    );

endinterface

// File: rtl/mux_scan_sequencer_finder.sv
// Priority encoder: lowest enabled channel at or above (incl_i=1) or strictly
// above (incl_i=0) the current select.
module next_chan_finder
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask_i,
    input  logic [SEL_W-1:0] cur_i,
    input  logic             incl_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             found_o
);

    // scan from the top down so the lowest qualifying channel wins
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (incl_i ? (SEL_W'(i) >= cur_i) : (SEL_W'(i) > cur_i))) begin
                nxt_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Time-shares one 16:1 mux: drives sel for every enabled channel, waits the
// settle time, samples mux_out and hands the packed snapshot downstream.
//
// state  | meaning
// IDLE   | waiting for start; sel holds its last value
// SETTLE | sel driven, counting settle clocks down to 1
// SAMPLE | capture mux_out into word[sel], move to next enabled channel
// DONE   | snapshot presented; wait for word_ready (start accepted on handshake)
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_sequencer_if.master bus,
    input  logic                 mux_out_i,
    output logic [SEL_W-1:0]     sel_o
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    // with no settle time each channel goes straight to sampling
    localparam state_e ARM_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_CH-1:0]  mask_q,  mask_d;
    logic [N_CH-1:0]  word_q,  word_d;
    logic             valid_q, valid_d;
    logic             accept;

    logic [SEL_W-1:0] first_ch;
    logic             first_found;
    logic [SEL_W-1:0] adv_ch;
    logic             adv_found;

    // first channel of a new scan comes straight from the incoming mask
    next_chan_finder u_first (
        .mask_i  (bus.mask),
        .cur_i   ('0),
        .incl_i  (1'b1),
        .nxt_o   (first_ch),
        .found_o (first_found)
    );

    // next channel of the scan in progress comes from the latched mask
    next_chan_finder u_adv (
        .mask_i  (mask_q),
        .cur_i   (sel_q),
        .incl_i  (1'b0),
        .nxt_o   (adv_ch),
        .found_o (adv_found)
    );

    // state and datapath registers; reset aborts any partial scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        word_d  = word_q;
        valid_d = valid_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = bus.start;
            end
            SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                word_d[sel_q] = mux_out_i;
                if (adv_found) begin
                    sel_d   = adv_ch;
                    cnt_d   = SETTLE_LD;
                    state_d = ARM_ST;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (valid_q && bus.word_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    accept  = bus.start;
                end else begin
                    // an empty-mask scan enters DONE with valid low; raise it here
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a new scan overrides whatever the current state decided
        if (accept) begin
            mask_d = bus.mask;
            word_d = '0;
            if (first_found) begin
                sel_d   = first_ch;
                cnt_d   = SETTLE_LD;
                state_d = ARM_ST;
            end else begin
                state_d = DONE;
                valid_d = 1'b0;
            end
        end
    end

    // outputs are straight register copies, busy everywhere except IDLE
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.word       = word_q;
        bus.word_valid = valid_q;
        sel_o          = sel_q;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 16:1 one-bit channel mux.
- Drives the mux select, waits a programmable settle time, and samples the mux's 1-bit output for every enabled channel.
- Assembles the samples into a 16-bit snapshot word and hands it downstream over a valid/ready handshake.
- Lets one mux be time-shared to capture a full 16-channel vector.

Parameters:
- N_CH, 16, number of mux channels; fixed at 16 for this mux.
- SEL_W, 4, select width, equal to clog2(N_CH).
- SETTLE_CYCLES, 1, clocks to wait after each sel change before sampling; range 0..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; accepted only in IDLE, or in DONE on the handshake cycle.
- mask  in  16  enabled channels; latched when start is accepted.
- mux_out  in  1  output of the 16:1 mux.
- sel  out  4  select driven to the mux.
- busy  out  1  high in SETTLE, SAMPLE and DONE.
- word  out  16  captured snapshot; bit k = sample of channel k, and 0 for masked-off channels.
- word_valid  out  1  snapshot available.
- word_ready  in  1  downstream accepts the snapshot.

Behaviour:
- Reset (async assert, sync deassert at the consumer): state IDLE, sel=0, busy=0, word=0, word_valid=0, settle counter=0, mask_q=0.
- A reset mid-scan aborts immediately and drops any partial word.
- State IDLE:
  - start=1 and mask!=0: latch mask_q, clear word, set sel to the lowest set bit of mask, load counter=SETTLE_CYCLES.
  - The next state is SETTLE, or SAMPLE directly if SETTLE_CYCLES=0.
  - start=1 and mask==0: go to DONE with word=0; word_valid is high 1 clock after the start edge.
- State SETTLE: counter decrements each clock; on the clock where counter==1, go to SAMPLE. sel is stable throughout.
- State SAMPLE (1 clock): word[sel] <= mux_out.
  - If mask_q has a set bit strictly above sel: sel <= that bit (lowest such), reload the counter, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
  - Otherwise: go to DONE and set word_valid=1.
- State DONE:
  - word and word_valid hold until word_valid and word_ready are both high.
  - On that handshake, word_valid drops next clock and the state returns to IDLE.
  - If start=1 in the same handshake cycle, the new scan is accepted directly, with the same actions as IDLE; this gives zero bubble.
- start outside IDLE and outside the DONE handshake cycle is ignored. It is not queued.
- mask changes after acceptance have no effect on the scan in progress.
- sel holds its last value in DONE and IDLE; it changes only as described above.
- Latency from the start edge to word_valid high is n*(SETTLE_CYCLES+1) clocks, where n = popcount(mask), or 1 clock when mask==0. Full mask with the default is 32 clocks.
- The channel sampled at a given edge is always the one whose sel has been stable for SETTLE_CYCLES+1 clocks.
- word bits for masked-off channels are always 0.

Decomposition:
- Shared package mux_scan_pkg:
  - constants N_CH=16 and SEL_W=4;
  - state enum {IDLE, SETTLE, SAMPLE, DONE} encoded in 2 bits.
- Sub-module next_chan_finder (combinational priority encoder):
  - inputs mask[15:0], cur[3:0], incl;
  - outputs nxt[3:0], found;
  - returns the lowest set bit >= cur when incl=1, or > cur when incl=0.
  - Used for both the first channel and the advance.
- The top level holds the FSM, settle counter, mask_q, word register and handshake.

Test Plan:
- Full scan: mask=16'hFFFF, the mux model's input bus drives 16'hA5C3, SETTLE_CYCLES=1, word_ready=1 -> word_valid rises exactly 32 clocks after start, word=16'hA5C3, sel steps 0..15 and each value is held 2 clocks.
- Sparse mask: mask=16'h8101, mux inputs=16'hFFFF -> sel visits 0, 8, 15 only, word=16'h8101, valid after 6 clocks.
- Zero mask: start with mask=0 -> word_valid after 1 clock, word=0, sel unchanged.
- Backpressure and back-to-back: hold word_ready=0 for 10 clocks after valid -> word stable and busy=1; a start pulse meanwhile is ignored. Then assert word_ready and start together with mask=16'h0002 -> new scan begins with no idle clock; second word_valid 2 clocks later.
- Reset mid-scan: assert rst_n=0 during the SETTLE of channel 5 -> outputs go to reset values asynchronously before the next edge; after release a new start yields a correct full word.
- Boundary SETTLE_CYCLES=0 (second build): full mask -> one channel per clock, valid 16 clocks after start, word matches the input pattern 16'h1234.
